// File: rtl/ex_mem_stage.sv
// rtl/ex_mem_stage.sv - EX/MEM pipeline register, NZCV flags and branch resolution (BR_STATS_EN adds branch counters)
module ex_mem_stage #(
    parameter int DATA_W     = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  ex_valid,
    input  logic [DATA_W-1:0]     ex_result,
    input  logic                  ex_zero,
    input  logic                  ex_negative,
    input  logic                  ex_carry,
    input  logic                  ex_overflow,
    input  logic                  ex_set_flags,
    input  logic [2:0]            ex_br_type,
    input  logic [3:0]            ex_cond,
    input  logic [DATA_W-1:0]     ex_br_target,
    input  logic [DATA_W-1:0]     ex_store_data,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_read,
    input  logic                  ex_mem_write,
    output logic                  mem_valid,
    output logic [DATA_W-1:0]     mem_result,
    output logic [DATA_W-1:0]     mem_store_data,
    output logic [DATA_W-1:0]     mem_br_target,
    output logic [REG_ADDR_W-1:0] mem_rd,
    output logic                  mem_reg_write,
    output logic                  mem_mem_read,
    output logic                  mem_mem_write,
    output logic                  mem_br_taken,
    output logic [3:0]            nzcv,
    output logic [31:0]           br_count,
    output logic [31:0]           taken_count
);

    localparam logic [2:0] BR_B    = 3'd1;
    localparam logic [2:0] BR_COND = 3'd2;
    localparam logic [2:0] BR_CBZ  = 3'd3;
    localparam logic [2:0] BR_CBNZ = 3'd4;

    // Odd condition codes are the negation of the even code below them, except E/F.
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] flags);
        logic n, z, c, v;
        logic base;
        {n, z, c, v} = flags;
        case (cond[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c & ~z;
            3'd5:    base = (n == v);
            3'd6:    base = ~z & (n == v);
            default: base = 1'b1;
        endcase
        if (cond[3:1] != 3'd7 && cond[0])
            cond_holds = ~base;
        else
            cond_holds = base;
    endfunction

    logic capture;
    logic squash;
    logic ex_is_branch;
    logic ex_taken;
    logic commit;

    assign capture      = ~stall;
    assign squash       = flush | (mem_valid & mem_br_taken);
    assign commit       = capture & ~squash & ex_valid;
    assign ex_is_branch = (ex_br_type != 3'd0) && (ex_br_type <= BR_CBNZ);

    // B.cond reads the architectural register, so a setter one slot ahead has already landed.
    always_comb begin
        ex_taken = 1'b0;
        case (ex_br_type)
            BR_B:    ex_taken = 1'b1;
            BR_COND: ex_taken = cond_holds(ex_cond, nzcv);
            BR_CBZ:  ex_taken = ex_zero;
            BR_CBNZ: ex_taken = ~ex_zero;
            default: ex_taken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_valid      <= 1'b0;
            mem_result     <= '0;
            mem_store_data <= '0;
            mem_br_target  <= '0;
            mem_rd         <= '0;
            mem_reg_write  <= 1'b0;
            mem_mem_read   <= 1'b0;
            mem_mem_write  <= 1'b0;
            mem_br_taken   <= 1'b0;
        end else if (capture) begin
            // Data fields are don't-care in a bubble, so they follow EX unconditionally.
            mem_result     <= ex_result;
            mem_store_data <= ex_store_data;
            mem_br_target  <= ex_br_target;
            mem_rd         <= ex_rd;
            if (squash) begin
                mem_valid     <= 1'b0;
                mem_reg_write <= 1'b0;
                mem_mem_read  <= 1'b0;
                mem_mem_write <= 1'b0;
                mem_br_taken  <= 1'b0;
            end else begin
                mem_valid     <= ex_valid;
                mem_reg_write <= ex_reg_write & ex_valid;
                mem_mem_read  <= ex_mem_read & ex_valid;
                mem_mem_write <= ex_mem_write & ex_valid;
                mem_br_taken  <= ex_taken & ex_valid;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            nzcv <= 4'b0000;
        else if (commit && ex_set_flags)
            nzcv <= {ex_negative, ex_zero, ex_carry, ex_overflow};
    end

`ifdef BR_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count    <= 32'd0;
            taken_count <= 32'd0;
        end else if (commit && ex_is_branch) begin
            br_count <= br_count + 32'd1;
            if (ex_taken)
                taken_count <= taken_count + 32'd1;
        end
    end
`else
    assign br_count    = 32'd0;
    assign taken_count = 32'd0;
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// tb/tb_ex_mem_stage.sv - directed bench for ex_mem_stage
module tb_ex_mem_stage;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [63:0] ex_result;
    logic        ex_zero, ex_negative, ex_carry, ex_overflow;
    logic        ex_set_flags;
    logic [2:0]  ex_br_type;
    logic [3:0]  ex_cond;
    logic [63:0] ex_br_target;
    logic [63:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write;
    logic        mem_valid;
    logic [63:0] mem_result, mem_store_data, mem_br_target;
    logic [4:0]  mem_rd;
    logic        mem_reg_write, mem_mem_read, mem_mem_write;
    logic        mem_br_taken;
    logic [3:0]  nzcv;
    logic [31:0] br_count, taken_count;

    int checks;
    int failures;

    ex_mem_stage #(.DATA_W(64), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_result(ex_result),
        .ex_zero(ex_zero), .ex_negative(ex_negative),
        .ex_carry(ex_carry), .ex_overflow(ex_overflow),
        .ex_set_flags(ex_set_flags), .ex_br_type(ex_br_type), .ex_cond(ex_cond),
        .ex_br_target(ex_br_target), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .mem_valid(mem_valid), .mem_result(mem_result), .mem_store_data(mem_store_data),
        .mem_br_target(mem_br_target), .mem_rd(mem_rd),
        .mem_reg_write(mem_reg_write), .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write),
        .mem_br_taken(mem_br_taken), .nzcv(nzcv),
        .br_count(br_count), .taken_count(taken_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [2:0] br, input logic [3:0] cond,
                         input logic [63:0] res, input logic [63:0] tgt, input logic [4:0] rd,
                         input logic rw, input logic mr, input logic sf, input logic [3:0] flags);
        ex_valid      = v;
        ex_br_type    = br;
        ex_cond       = cond;
        ex_result     = res;
        ex_store_data = ~res;
        ex_br_target  = tgt;
        ex_rd         = rd;
        ex_reg_write  = rw;
        ex_mem_read   = mr;
        ex_mem_write  = 1'b0;
        ex_set_flags  = sf;
        {ex_negative, ex_zero, ex_carry, ex_overflow} = flags;
    endtask

    task automatic idle();
        drive(1'b0, 3'd0, 4'h0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 1'b0, 4'b0000);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        idle();
        repeat (2) tick();
        check("rst_valid", mem_valid, 0);
        check("rst_nzcv", nzcv, 0);
        check("rst_taken", mem_br_taken, 0);
        check("rst_result", mem_result, 0);
        rst_n = 1'b1;

        // SUBS 5-5
        drive(1, 3'd0, 4'h0, 64'h0, 64'h0, 5'd1, 1, 0, 1, 4'b0110);
        tick();
        check("subs_nzcv", nzcv, 4'b0110);
        check("subs_result", mem_result, 0);
        check("subs_valid", mem_valid, 1);
        check("subs_rw", mem_reg_write, 1);

        // B.cond EQ
        drive(1, 3'd2, 4'h0, 64'h0, 64'h100, 5'd0, 0, 0, 0, 4'b0000);
        tick();
        check("eq_taken", mem_br_taken, 1);
        check("eq_target", mem_br_target, 64'h100);

        // ADDS in the shadow of the taken branch
        drive(1, 3'd0, 4'h0, 64'h5, 64'h0, 5'd3, 1, 0, 1, 4'b1000);
        tick();
        check("shadow1_valid", mem_valid, 0);
        check("shadow1_rw", mem_reg_write, 0);
        check("shadow1_nzcv", nzcv, 4'b0110);
        check("shadow1_taken", mem_br_taken, 0);

        // B.cond HI with C=1 Z=1
        drive(1, 3'd2, 4'h8, 64'h0, 64'h110, 5'd0, 0, 0, 0, 4'b0000);
        tick();
        check("hi_taken", mem_br_taken, 0);
        check("hi_valid", mem_valid, 1);

        drive(1, 3'd3, 4'h0, 64'h7, 64'h120, 5'd0, 0, 0, 0, 4'b0000);
        tick();
        check("cbz_taken", mem_br_taken, 0);

        drive(1, 3'd4, 4'h0, 64'h7, 64'h40, 5'd0, 0, 0, 0, 4'b0000);
        tick();
        check("cbnz_taken", mem_br_taken, 1);
        check("cbnz_target", mem_br_target, 64'h40);

        drive(1, 3'd1, 4'h0, 64'h0, 64'h60, 5'd0, 0, 0, 0, 4'b0000);
        tick();
        check("bsq_taken", mem_br_taken, 0);
        check("bsq_valid", mem_valid, 0);

        drive(1, 3'd1, 4'h0, 64'h0, 64'h80, 5'd0, 0, 0, 0, 4'b0000);
        tick();
        check("b_taken", mem_br_taken, 1);
        check("b_target", mem_br_target, 64'h80);

        drive(1, 3'd0, 4'h0, 64'h9, 64'h0, 5'd3, 1, 0, 1, 4'b1000);
        tick();
        check("shadow2_valid", mem_valid, 0);
        check("shadow2_rw", mem_reg_write, 0);
        check("shadow2_nzcv", nzcv, 4'b0110);

        // Load, then stall three cycles with a flush in the middle
        drive(1, 3'd0, 4'h0, 64'hDEAD, 64'h0, 5'd7, 1, 1, 0, 4'b0000);
        tick();
        check("ld_result", mem_result, 64'hDEAD);
        check("ld_rd", mem_rd, 7);
        check("ld_read", mem_mem_read, 1);
        check("ld_store", mem_store_data, ~64'hDEAD);
        drive(1, 3'd0, 4'h0, 64'h1234, 64'h0, 5'd9, 1, 0, 1, 4'b1111);
        stall = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        check("stall_result", mem_result, 64'hDEAD);
        check("stall_rd", mem_rd, 7);
        check("stall_valid", mem_valid, 1);
        check("stall_nzcv", nzcv, 4'b0110);
        stall = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_valid", mem_valid, 0);
        check("flush_read", mem_mem_read, 0);
        check("flush_nzcv", nzcv, 4'b0110);

        // Taken branch held across a stall
        drive(1, 3'd1, 4'h0, 64'h0, 64'h200, 5'd0, 0, 0, 0, 4'b0000);
        tick();
        check("bst_taken", mem_br_taken, 1);
        idle();
        stall = 1'b1;
        tick();
        tick();
        check("bst_hold_taken", mem_br_taken, 1);
        check("bst_hold_target", mem_br_target, 64'h200);
        stall = 1'b0;
        tick();
        check("bst_release", mem_br_taken, 0);

        drive(1, 3'd0, 4'h0, 64'h0, 64'h0, 5'd2, 1, 0, 1, 4'b1001);
        tick();
        check("set_nzcv", nzcv, 4'b1001);

        drive(1, 3'd2, 4'hB, 64'h0, 64'h300, 5'd0, 0, 0, 0, 4'b0000);
        tick();
        check("lt_taken", mem_br_taken, 0);
        check("lt_valid", mem_valid, 1);
        drive(1, 3'd2, 4'hA, 64'h0, 64'h340, 5'd0, 0, 0, 0, 4'b0000);
        tick();
        check("ge_taken", mem_br_taken, 1);
        check("ge_target", mem_br_target, 64'h340);
        idle();
        tick();

        drive(1, 3'd1, 4'h0, 64'h0, 64'h400, 5'd0, 0, 0, 0, 4'b0000);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        idle();
        check("fb_valid", mem_valid, 0);
        check("fb_taken", mem_br_taken, 0);
`ifdef BR_STATS_EN
        check("br_count", br_count, 8);
        check("taken_count", taken_count, 5);
`else
        check("br_count", br_count, 0);
        check("taken_count", taken_count, 0);
`endif

        // Load something live, then reset between edges
        drive(1, 3'd0, 4'h0, 64'hBEEF, 64'h0, 5'd4, 1, 0, 1, 4'b1110);
        tick();
        check("pre_rst_result", mem_result, 64'hBEEF);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_nzcv", nzcv, 0);
        check("arst_valid", mem_valid, 0);
        check("arst_result", mem_result, 0);
        check("arst_rd", mem_rd, 0);
        check("arst_rw", mem_reg_write, 0);
        check("arst_br_count", br_count, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute-to-memory stage boundary of the 5-stage pipelined CPU. Sits directly downstream of the 64-bit ALU. It captures the ALU result and flags into the EX/MEM pipeline register and holds the architectural NZCV flag register. It resolves B, B.cond, CBZ and CBNZ, and presents a registered branch redirect to the fetch stage. It also squashes the wrong-path instruction behind a taken branch.

## Interface
- DATA_W, 64, datapath width (ALU result, store data, branch target)
- REG_ADDR_W, 5, destination register index width

- clk  input  1  pipeline clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- stall  input  1  hold EX/MEM register and NZCV
- flush  input  1  load a bubble at next capture edge
- ex_valid  input  1  EX holds a real instruction
- ex_result  input  DATA_W  ALU Result
- ex_zero, ex_negative, ex_carry, ex_overflow  input  1 each  ALU Zero/Negative/CarryOut/Overflow
- ex_set_flags  input  1  instruction writes NZCV (ADDS/SUBS/ANDS)
- ex_br_type  input  3  0 none, 1 B, 2 B.cond, 3 CBZ, 4 CBNZ, 5–7 treated as none
- ex_cond  input  4  ARM condition code for B.cond
- ex_br_target  input  DATA_W  computed branch target
- ex_store_data  input  DATA_W  register value for STUR
- ex_rd  input  REG_ADDR_W  destination register
- ex_reg_write, ex_mem_read, ex_mem_write  input  1 each  control bits
- mem_valid  output  1  MEM holds a real instruction
- mem_result, mem_store_data, mem_br_target  output  DATA_W  registered copies
- mem_rd  output  REG_ADDR_W  registered destination
- mem_reg_write, mem_mem_read, mem_mem_write  output  1 each  registered controls, forced 0 in a bubble
- mem_br_taken  output  1  redirect fetch to mem_br_target
- nzcv  output  4  {N,Z,C,V} architectural flags
- br_count, taken_count  output  32 each  branch statistics (see Configuration)

## Operation
- capture = !stall. squash = flush | (mem_valid & mem_br_taken).
- At a capture edge with squash=1: mem_valid, all mem control bits and mem_br_taken load 0. Data fields may load anything. NZCV is unchanged.
- At a capture edge with squash=0: every mem_* field loads its ex_* counterpart. mem_valid loads ex_valid. Control bits and mem_br_taken are ANDed with ex_valid.
- NZCV loads {ex_negative, ex_zero, ex_carry, ex_overflow} only at a capture edge with squash=0, ex_valid=1 and ex_set_flags=1.
- Branch decision is combinational in EX and registered into mem_br_taken:
  - B: taken.
  - CBZ: taken if ex_zero. The ALU is run in pass-B mode, so Zero reflects Rt==0.
  - CBNZ: taken if !ex_zero.
  - B.cond: evaluated on the current nzcv register, not on the ex_* flags.
- Condition codes:
  - 0 EQ Z; 1 NE !Z; 2 HS C; 3 LO !C
  - 4 MI N; 5 PL !N; 6 VS V; 7 VC !V
  - 8 HI C&!Z; 9 LS !(C&!Z)
  - A GE N==V; B LT N!=V
  - C GT !Z&(N==V); D LE !(!Z&(N==V))
  - E/F always.
- ex_set_flags on a branch instruction is honoured. The flag update and the branch decision use pre-update nzcv.
- A flag-setting instruction immediately followed by B.cond needs no bypass. NZCV updates at the edge the setter leaves EX, which is before B.cond evaluates.
- Priority: rst_n > stall > squash. While stall=1, flush has no effect and is not remembered.

## Timing
- Latency: EX inputs appear on mem_* one cycle after a capture edge. nzcv updates at that same edge.
- mem_br_taken is high for exactly one capture cycle per taken branch. It stays high across stall cycles.
- The instruction in EX during the cycle mem_br_taken=1 is squashed. The upstream hazard unit flushes IF/ID.
- Reset, asynchronous, takes effect mid-operation without waiting for clk:
  - all mem_* outputs 0, mem_valid 0, mem_br_taken 0
  - nzcv 4'b0000, counters 0.
- First capture edge after rst_n deasserts behaves normally.

## Configuration
- BR_STATS_EN defined:
  - br_count increments on each capture edge with squash=0, ex_valid=1 and ex_br_type in 1–4.
  - taken_count increments when such a branch is also taken.
  - Both counters wrap modulo 2^32 and hold during stall.
- BR_STATS_EN undefined: no counter logic; br_count and taken_count are tied to 0.

## Test plan
- SUBS 5-5: ex_result=0, zero=1, carry=1, overflow=0, set_flags=1 -> next cycle nzcv=4'b0110, mem_result=0. Then B.cond EQ, target 0x100 -> mem_br_taken=1, mem_br_target=0x100.
- CBZ with ex_zero=0 -> mem_br_taken=0. CBNZ with ex_zero=0, target 0x40 -> mem_br_taken=1, mem_br_target=0x40.
- Taken B in MEM; EX holds ADDS rd=3 with reg_write=1, set_flags=1 -> next cycle mem_valid=0, mem_reg_write=0, nzcv unchanged.
- Load rd=7 result 0xDEAD; stall=1 for 3 cycles with flush=1 in cycle 2 -> mem_result=0xDEAD, mem_rd=7 held. After stall drops with flush=1 -> bubble (mem_valid=0).
- Flags nzcv=4'b1001; B.cond GE and LT back to back -> GE taken, LT not taken. Assert rst_n=0 between clock edges -> nzcv and all mem_* outputs 0 immediately.
- BR_STATS_EN: issue 4 branches, 3 taken, one of them squashed by flush -> br_count=3, taken_count=2.
